result_serializer: RTL
======================

// Module: result_serializer
// PURPOSE
//  Downstream of the processing core. Streams one operation result out as bytes to the UART transmitter.
//  Scalar result (Euclidean distance / dot product): 4 bytes, little-endian.
//  Vector result: 2 bytes per element, element 0 first, LSB byte first.
//  Driven by the core's result-valid pulse and the output-mode flag.
// PARAMETERS
//  WIDTH   10     bits per vector element; must be <= 16
//  DEPTH   1024   vector elements
//  SW      $clog2(DEPTH)+10+WIDTH (30)   scalar result width; must be <= 32
// PORTS
//  clk         in   1              system clock, single clock domain
//  rst         in   1              synchronous, active-high reset
//  start       in   1              1-cycle pulse (core res_vld); begins a transfer
//  out_mode    in   1              0 = scalar result, 1 = vector result; sampled with start
//  scalar_in   in   SW             scalar result; captured on start
//  vec_in      in   DEPTH*WIDTH    packed [DEPTH-1:0][WIDTH-1:0]; must stay stable while busy=1
//  tx_data     out  8              byte to the UART transmitter
//  tx_start    out  1              1-cycle request to send tx_data
//  tx_busy     in   1              UART busy; rises within 2 cycles of tx_start, falls when the byte is done
//  busy        out  1              transfer in progress
//  done        out  1              1-cycle pulse after the final byte completes
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Takes effect on the next clk edge, from any state.
//  Reset mid-transfer: abandons the transfer. No done pulse. tx_start deasserts next cycle.
//  FSM states:
//   IDLE -> LOAD on start=1.
//   LOAD: capture scalar_in into scal_q, out_mode into mode_q; clear byte_cnt; busy=1.
//   LOAD -> SEND (1 cycle).
//   SEND: if tx_busy=0, drive tx_data and tx_start=1 for exactly one cycle, then -> WAIT_HI.
//         If tx_busy=1, wait in SEND.
//   WAIT_HI: hold until tx_busy=1, then -> WAIT_LO.
//            No timeout; tx_busy is guaranteed to rise.
//   WAIT_LO: on tx_busy=0, byte_cnt++.
//            If byte_cnt == LAST -> DONE, else -> SEND.
//   DONE: done=1 for one cycle, busy=0, then -> IDLE.
//  Byte counts (LAST = N-1):
//   scalar: N = 4
//   vector: N = 2*DEPTH
//   byte_cnt width: $clog2(2*DEPTH)
//  Byte selection:
//   scalar: tx_data = {zero-pad to 32 bits, scal_q}[8*byte_cnt +: 8]
//   vector: elem = byte_cnt >> 1; word = {zero-pad to 16 bits, vec_in[elem]}
//           byte_cnt[0] = 0 -> word[7:0]; byte_cnt[0] = 1 -> word[15:8]
//  tx_data is registered. It is updated in the same cycle tx_start is raised and held until the next SEND.
//  Simultaneous events:
//   start while busy=1 or in DONE: ignored (no queueing).
//   start in the same cycle as rst: rst wins.
//  busy is 1 from the LOAD cycle through the cycle before DONE. It is 0 in the DONE cycle itself.
//  Latency: start -> first tx_start = 3 cycles (IDLE -> LOAD -> SEND, tx_start registered), when tx_busy=0.
// STRUCTURE
//  Package result_serializer_pkg:
//   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, DONE} ser_state_t;
//   localparam SCALAR_BYTES = 4; localparam BYTES_PER_ELEM = 2.
//  Sub-module result_byte_mux (combinational): selects the byte from scal_q / vec_in, mode_q and byte_cnt.
//  The top level holds the FSM, the counter and the output registers.
// TESTING
//  Bench uses DEPTH=4, WIDTH=10 and a UART model whose tx_busy rises 1 cycle after tx_start and stays high 5 cycles.
//  1 Scalar, out_mode=0, scalar_in=30'h2ABC_DEF1, start pulse
//    -> bytes F1, DE, BC, 2A in order; exactly 4 tx_start pulses; one done pulse; busy=0 afterwards.
//  2 Vector, out_mode=1, vec_in={10'h3FF, 10'h200, 10'h0FF, 10'h001} (elem 3..0)
//    -> bytes 01, 00, FF, 00, 00, 02, FF, 03; one done pulse.
//  3 Start pulse during byte 2 of a scalar transfer
//    -> ignored; still exactly 4 bytes; exactly one done pulse.
//  4 rst asserted in WAIT_LO of byte 1
//    -> next cycle busy=0, tx_start=0, no done pulse.
//    -> a new start then sends the full 4 bytes from byte 0.
//  5 tx_busy held high for 20 cycles before start
//    -> FSM waits in SEND; first tx_start comes 1 cycle after tx_busy falls.
//  6 Back-to-back: start on the cycle after done
//    -> accepted; the second transfer completes correctly.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// Shared types and constants for the result byte serializer.
package result_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO,
        DONE
    } ser_state_t;

    localparam int unsigned SCALAR_BYTES   = 4;
    localparam int unsigned BYTES_PER_ELEM = 2;

endpackage

// File: rtl/result_byte_mux.sv
// Combinational selection of the next byte to transmit from the scalar or vector result.
module result_byte_mux
    import result_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned SW    = 30,
    parameter int unsigned CNTW  = 11
) (
    input  logic [SW-1:0]          scal,
    input  logic [DEPTH*WIDTH-1:0] vec_in,
    input  logic                   mode,
    input  logic [CNTW-1:0]        byte_cnt,
    output logic [7:0]             byte_c
);

    logic [DEPTH-1:0][WIDTH-1:0] elems;
    logic [31:0]                 scal_w;
    logic [15:0]                 word;

    always_comb begin
        elems  = vec_in;
        scal_w = 32'(scal);
        // Element index is the byte count without its low (byte-within-element) bit.
        word   = 16'(elems[byte_cnt[CNTW-1:1]]);
        byte_c = 8'h00;
        if (mode) begin
            byte_c = byte_cnt[0] ? word[15:8] : word[7:0];
        end else begin
            case (byte_cnt[1:0])
                2'd0:    byte_c = scal_w[7:0];
                2'd1:    byte_c = scal_w[15:8];
                2'd2:    byte_c = scal_w[23:16];
                default: byte_c = scal_w[31:24];
            endcase
        end
    end

endmodule

// File: rtl/result_serializer.sv
// Streams one scalar or vector result to a UART transmitter, one byte per tx handshake.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned SW    = $clog2(DEPTH) + 10 + WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   out_mode,
    input  logic [SW-1:0]          scalar_in,
    input  logic [DEPTH*WIDTH-1:0] vec_in,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNTW = $clog2(BYTES_PER_ELEM * DEPTH);
    localparam logic [CNTW-1:0] LAST_SCAL = CNTW'(SCALAR_BYTES - 1);
    localparam logic [CNTW-1:0] LAST_VEC  = CNTW'(BYTES_PER_ELEM * DEPTH - 1);

    ser_state_t      state_q, state_d;
    logic [SW-1:0]   scal_q, scal_d;
    logic            mode_q, mode_d;
    logic [CNTW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      byte_c;
    logic [CNTW-1:0] last_c;

    result_byte_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SW    (SW),
        .CNTW  (CNTW)
    ) u_byte_mux (
        .scal     (scal_q),
        .vec_in   (vec_in),
        .mode     (mode_q),
        .byte_cnt (byte_cnt_q),
        .byte_c   (byte_c)
    );

    assign last_c = mode_q ? LAST_VEC : LAST_SCAL;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        scal_d     = scal_q;
        mode_d     = mode_q;
        byte_cnt_d = byte_cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Result and mode are only guaranteed valid alongside the start pulse.
                    scal_d  = scalar_in;
                    mode_d  = out_mode;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                byte_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = byte_c;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    byte_cnt_d = byte_cnt_q + CNTW'(1);
                    state_d    = (byte_cnt_q == last_c) ? DONE : SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = state_d inside {LOAD, SEND, WAIT_HI, WAIT_LO};
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scal_q     <= '0;
            mode_q     <= 1'b0;
            byte_cnt_q <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scal_q     <= scal_d;
            mode_q     <= mode_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
